wake_sched: RTL

- Controller that sits between the per-frame classifier stream and the system wake output.
- Debounces detections: the wake class must be hit on N consecutive frames.
- Then asserts wake for a programmable hold time, followed by a programmable refractory (cooldown) period in which detections are ignored.
- Hold, cooldown and hit-threshold values come from a small config register write port driven by the host interface.

---
 rtl/wake_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/wake_sched.sv
`default_nettype none
// ============================================================================
// Module      : wake_sched
// Description : Wake-word scheduler. Debounces per-frame classifier hits,
//               raises a wake level for a programmable hold time, then
//               enforces a programmable cooldown in which frames are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module wake_sched #(
   parameter int unsigned NUM_CLASSES = 3,
   parameter int unsigned WAKE_CLASS  = 0,
   parameter int unsigned CNT_BW      = 24,
   parameter int unsigned HIT_BW      = 4,
   parameter int unsigned HOLD_RST    = 8000000,
   parameter int unsigned COOL_RST    = 1600000,
   parameter int unsigned THRESH_RST  = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [NUM_CLASSES-1:0] data_i,
   input  logic                   valid_i,
   input  logic                   last_i,
   output logic                   ready_o,
   input  logic                   cfg_we_i,
   input  logic [1:0]             cfg_addr_i,
   input  logic [CNT_BW-1:0]      cfg_data_i,
   output logic                   wake_o,
   output logic                   trig_o,
   output logic [1:0]             state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAKE = 2'd1,
      ST_COOL = 2'd2
   } state_t;

   localparam logic [HIT_BW-1:0] c_hit_one = HIT_BW'(1);
   localparam logic [CNT_BW-1:0] c_cnt_one = CNT_BW'(1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [HIT_BW-1:0]   r_hit_cnt;
   logic [HIT_BW-1:0]   w_hit_cnt_nxt;
   logic [CNT_BW-1:0]   r_ctr;
   logic [CNT_BW-1:0]   w_ctr_nxt;
   logic [CNT_BW-1:0]   r_hold_len;
   logic [CNT_BW-1:0]   r_cool_len;
   logic [HIT_BW-1:0]   r_hit_thresh;
   logic                r_ready;
   logic                r_wake;
   logic                r_trig;

   logic                w_beat;
   logic                w_hit;
   logic                w_fire;
   logic [HIT_BW-1:0]   w_thr;
   logic [CNT_BW-1:0]   w_hl;
   logic [HIT_BW:0]     w_hit_inc;
   logic                w_unused_bits;

   // Only the wake class bit matters; the other class bits are deliberately ignored.
   assign w_unused_bits = ^data_i;

   assign w_beat    = valid_i & r_ready;
   assign w_hit     = data_i[WAKE_CLASS];
   // A programmed zero means "at least one": a threshold of 0 behaves as 1, a hold of 0 as 1 cycle.
   assign w_thr     = (r_hit_thresh == '0) ? c_hit_one : r_hit_thresh;
   assign w_hl      = (r_hold_len == '0) ? c_cnt_one : r_hold_len;
   // One extra bit so the threshold compare sees the true count even at all-ones.
   assign w_hit_inc = {1'b0, r_hit_cnt} + {{HIT_BW{1'b0}}, 1'b1};
   assign w_fire    = (r_state == ST_IDLE) && w_beat && w_hit && (w_hit_inc >= {1'b0, w_thr});

   assign ready_o = r_ready;
   assign wake_o  = r_wake;
   assign trig_o  = r_trig;
   assign state_o = r_state;

   // State, counters and registered outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state   <= ST_IDLE;
         r_hit_cnt <= '0;
         r_ctr     <= '0;
         r_ready   <= 1'b0;
         r_wake    <= 1'b0;
         r_trig    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_hit_cnt <= w_hit_cnt_nxt;
         r_ctr     <= w_ctr_nxt;
         r_ready   <= 1'b1;
         r_wake    <= (w_state_nxt == ST_WAKE);
         r_trig    <= w_fire;
      end
   end

   // Config registers; writes only land while idle so a running wake/cooldown is never disturbed.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_hold_len   <= CNT_BW'(HOLD_RST);
         r_cool_len   <= CNT_BW'(COOL_RST);
         r_hit_thresh <= HIT_BW'(THRESH_RST);
      end else if (cfg_we_i && (r_state == ST_IDLE)) begin
         case (cfg_addr_i)
            2'd0:    r_hold_len   <= cfg_data_i;
            2'd1:    r_cool_len   <= cfg_data_i;
            2'd2:    r_hit_thresh <= cfg_data_i[HIT_BW-1:0];
            default: ;
         endcase
      end
   end

   // Next-state, hit-counter and duration-counter logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_hit_cnt_nxt = r_hit_cnt;
      w_ctr_nxt     = r_ctr;
      case (r_state)
         ST_IDLE: begin
            w_ctr_nxt = '0;
            if (w_beat) begin
               if (w_fire) begin
                  w_state_nxt   = ST_WAKE;
                  w_hit_cnt_nxt = '0;
               end else if (w_hit) begin
                  w_hit_cnt_nxt = (&r_hit_cnt) ? r_hit_cnt : w_hit_inc[HIT_BW-1:0];
               end else begin
                  w_hit_cnt_nxt = '0;
               end
               // End of an utterance segment breaks any partial run of hits.
               if (last_i && !w_fire) begin
                  w_hit_cnt_nxt = '0;
               end
            end
         end
         ST_WAKE: begin
            if (r_ctr == (w_hl - c_cnt_one)) begin
               w_ctr_nxt   = '0;
               w_state_nxt = (r_cool_len != '0) ? ST_COOL : ST_IDLE;
            end else begin
               w_ctr_nxt = r_ctr + c_cnt_one;
            end
         end
         ST_COOL: begin
            if (r_ctr == (r_cool_len - c_cnt_one)) begin
               w_ctr_nxt     = '0;
               w_hit_cnt_nxt = '0;
               w_state_nxt   = ST_IDLE;
            end else begin
               w_ctr_nxt = r_ctr + c_cnt_one;
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_ctr_nxt     = '0;
            w_hit_cnt_nxt = '0;
         end
      endcase
   end

endmodule
`default_nettype wire
